// File: rtl/core_types_pkg.sv
// Shared dispatch/ROB/map-table types and the recovery sequencer state encoding.
// ROB index arithmetic relies on ROB_index_t being exactly log2(ROB depth) wide.
package core_types_pkg;

    typedef logic [4:0] ROB_index_t;
    typedef logic [2:0] checkpoint_column_t;
    typedef logic [4:0] arch_reg_tag_t;
    typedef logic [5:0] phys_reg_tag_t;

    typedef enum logic [1:0] {
        RECOV_IDLE    = 2'd0,
        RECOV_RESTORE = 2'd1,
        RECOV_WALK    = 2'd2,
        RECOV_DONE    = 2'd3
    } recovery_state_t;

    function automatic ROB_index_t rob_inc(input ROB_index_t idx);
        return idx + ROB_index_t'(1);
    endfunction

endpackage

// File: rtl/map_table_recovery_controller.sv
// Mispredict recovery of the map table: one-cycle checkpoint restore, else a youngest-first ROB walk.
// Request accepted only in IDLE; dispatch is stalled from acceptance until the DONE cycle completes.
module map_table_recovery_controller
    import core_types_pkg::*;
#(
    parameter bit USE_CHECKPOINTS = 1'b1,
    parameter int ROB_ENTRIES     = 2**$bits(ROB_index_t)
) (
    input  logic               CLK,
    input  logic               nRST,
    output logic               DUT_error,
    input  logic               recover_req_valid,
    output logic               recover_req_ready,
    input  ROB_index_t         recover_ROB_index,
    input  logic               recover_checkpoint_valid,
    input  checkpoint_column_t recover_checkpoint_column,
    input  ROB_index_t         ROB_tail_index,
    output ROB_index_t         ROB_read_index,
    input  logic               ROB_read_writes_reg,
    input  arch_reg_tag_t      ROB_read_dest_arch_reg_tag,
    input  phys_reg_tag_t      ROB_read_safe_phys_reg_tag,
    input  phys_reg_tag_t      ROB_read_speculated_phys_reg_tag,
    output logic               revert_valid,
    output arch_reg_tag_t      revert_dest_arch_reg_tag,
    output phys_reg_tag_t      revert_safe_dest_phys_reg_tag,
    output phys_reg_tag_t      revert_speculated_dest_phys_reg_tag,
    output logic               restore_checkpoint_valid,
    output logic               restore_checkpoint_speculate_failed,
    output ROB_index_t         restore_checkpoint_ROB_index,
    output checkpoint_column_t restore_checkpoint_safe_column,
    input  logic               restore_checkpoint_success,
    output logic               dispatch_stall,
    output logic               recover_done,
    output ROB_index_t         recover_new_ROB_tail
);

    function automatic ROB_index_t rob_dec(input ROB_index_t idx);
        return ROB_index_t'((32'(idx) + ROB_ENTRIES - 1) % ROB_ENTRIES);
    endfunction

    recovery_state_t    state_q, state_d;
    ROB_index_t         branch_q, branch_d;
    ROB_index_t         tail_q, tail_d;
    ROB_index_t         ptr_q, ptr_d;
    checkpoint_column_t column_q, column_d;
    logic               error_q, error_d;

    logic in_idle, in_restore, in_walk, in_done;
    assign in_idle    = (state_q == RECOV_IDLE);
    assign in_restore = (state_q == RECOV_RESTORE);
    assign in_walk    = (state_q == RECOV_WALK);
    assign in_done    = (state_q == RECOV_DONE);

    always_comb begin
        state_d  = state_q;
        branch_d = branch_q;
        tail_d   = tail_q;
        ptr_d    = ptr_q;
        column_d = column_q;
        error_d  = error_q;
        unique case (state_q)
            RECOV_IDLE: begin
                if (recover_req_valid) begin
                    branch_d = recover_ROB_index;
                    tail_d   = ROB_tail_index;
                    column_d = recover_checkpoint_column;
                    ptr_d    = rob_dec(ROB_tail_index);
                    if (recover_checkpoint_valid && USE_CHECKPOINTS)
                        state_d = RECOV_RESTORE;
                    else if (ROB_tail_index == rob_inc(recover_ROB_index))
                        state_d = RECOV_DONE;
                    else
                        state_d = RECOV_WALK;
                end
            end
            RECOV_RESTORE: begin
                // Failed restore falls back to the walk, which always starts from the youngest entry.
                ptr_d = rob_dec(tail_q);
                if (restore_checkpoint_success || (tail_q == rob_inc(branch_q)))
                    state_d = RECOV_DONE;
                else
                    state_d = RECOV_WALK;
            end
            RECOV_WALK: begin
                if (ROB_read_writes_reg && (ROB_read_dest_arch_reg_tag == '0))
                    error_d = 1'b1;
                if (ptr_q == rob_inc(branch_q))
                    state_d = RECOV_DONE;
                else
                    ptr_d = rob_dec(ptr_q);
            end
            RECOV_DONE: state_d = RECOV_IDLE;
            default:    state_d = RECOV_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= RECOV_IDLE;
            branch_q <= '0;
            tail_q   <= '0;
            ptr_q    <= '0;
            column_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            branch_q <= branch_d;
            tail_q   <= tail_d;
            ptr_q    <= ptr_d;
            column_q <= column_d;
            error_q  <= error_d;
        end
    end

    assign DUT_error         = error_q;
    assign recover_req_ready = in_idle;
    assign dispatch_stall    = !in_idle;

    // Map-table-facing fields are zeroed outside their own state so the map table never sees stale tags.
    assign ROB_read_index                      = in_walk ? ptr_q : '0;
    assign revert_valid                        = in_walk && ROB_read_writes_reg && (ROB_read_dest_arch_reg_tag != '0);
    assign revert_dest_arch_reg_tag            = in_walk ? ROB_read_dest_arch_reg_tag : '0;
    assign revert_safe_dest_phys_reg_tag       = in_walk ? ROB_read_safe_phys_reg_tag : '0;
    assign revert_speculated_dest_phys_reg_tag = in_walk ? ROB_read_speculated_phys_reg_tag : '0;

    assign restore_checkpoint_valid            = in_restore;
    assign restore_checkpoint_speculate_failed = in_restore;
    assign restore_checkpoint_ROB_index        = in_restore ? branch_q : '0;
    assign restore_checkpoint_safe_column      = in_restore ? column_q : '0;

    assign recover_done         = in_done;
    assign recover_new_ROB_tail = in_done ? rob_inc(branch_q) : '0;

endmodule

// File: tb/tb_map_table_recovery_controller.sv
// Directed bench for the map table recovery sequencer with a small ROB contents model.
module tb_map_table_recovery_controller;
    import core_types_pkg::*;

    logic               CLK = 1'b0;
    logic               nRST;
    logic               DUT_error;
    logic               recover_req_valid;
    logic               recover_req_ready;
    ROB_index_t         recover_ROB_index;
    logic               recover_checkpoint_valid;
    checkpoint_column_t recover_checkpoint_column;
    ROB_index_t         ROB_tail_index;
    ROB_index_t         ROB_read_index;
    logic               ROB_read_writes_reg;
    arch_reg_tag_t      ROB_read_dest_arch_reg_tag;
    phys_reg_tag_t      ROB_read_safe_phys_reg_tag;
    phys_reg_tag_t      ROB_read_speculated_phys_reg_tag;
    logic               revert_valid;
    arch_reg_tag_t      revert_dest_arch_reg_tag;
    phys_reg_tag_t      revert_safe_dest_phys_reg_tag;
    phys_reg_tag_t      revert_speculated_dest_phys_reg_tag;
    logic               restore_checkpoint_valid;
    logic               restore_checkpoint_speculate_failed;
    ROB_index_t         restore_checkpoint_ROB_index;
    checkpoint_column_t restore_checkpoint_safe_column;
    logic               restore_checkpoint_success;
    logic               dispatch_stall;
    logic               recover_done;
    ROB_index_t         recover_new_ROB_tail;

    map_table_recovery_controller #(.USE_CHECKPOINTS(1'b1), .ROB_ENTRIES(32)) dut (
        .CLK(CLK), .nRST(nRST), .DUT_error(DUT_error),
        .recover_req_valid(recover_req_valid), .recover_req_ready(recover_req_ready),
        .recover_ROB_index(recover_ROB_index),
        .recover_checkpoint_valid(recover_checkpoint_valid),
        .recover_checkpoint_column(recover_checkpoint_column),
        .ROB_tail_index(ROB_tail_index), .ROB_read_index(ROB_read_index),
        .ROB_read_writes_reg(ROB_read_writes_reg),
        .ROB_read_dest_arch_reg_tag(ROB_read_dest_arch_reg_tag),
        .ROB_read_safe_phys_reg_tag(ROB_read_safe_phys_reg_tag),
        .ROB_read_speculated_phys_reg_tag(ROB_read_speculated_phys_reg_tag),
        .revert_valid(revert_valid), .revert_dest_arch_reg_tag(revert_dest_arch_reg_tag),
        .revert_safe_dest_phys_reg_tag(revert_safe_dest_phys_reg_tag),
        .revert_speculated_dest_phys_reg_tag(revert_speculated_dest_phys_reg_tag),
        .restore_checkpoint_valid(restore_checkpoint_valid),
        .restore_checkpoint_speculate_failed(restore_checkpoint_speculate_failed),
        .restore_checkpoint_ROB_index(restore_checkpoint_ROB_index),
        .restore_checkpoint_safe_column(restore_checkpoint_safe_column),
        .restore_checkpoint_success(restore_checkpoint_success),
        .dispatch_stall(dispatch_stall), .recover_done(recover_done),
        .recover_new_ROB_tail(recover_new_ROB_tail)
    );

    always #5 CLK = ~CLK;

    // ROB contents: arch = (i%31)+1, safe = i|0x20, spec = i, all writing unless overridden.
    logic          rob_wr   [32];
    arch_reg_tag_t rob_arch [32];
    phys_reg_tag_t rob_safe [32];
    phys_reg_tag_t rob_spec [32];

    always_comb begin
        ROB_read_writes_reg              = rob_wr[ROB_read_index];
        ROB_read_dest_arch_reg_tag       = rob_arch[ROB_read_index];
        ROB_read_safe_phys_reg_tag       = rob_safe[ROB_read_index];
        ROB_read_speculated_phys_reg_tag = rob_spec[ROB_read_index];
    end

    int         n_checks = 0;
    int         n_fail   = 0;
    int         mon_stall = 0, mon_revert = 0, mon_restore = 0, mon_overlap = 0;
    ROB_index_t walk_q[$];
    logic [4:0] last_arch;
    logic [5:0] last_safe, last_spec;

    always @(negedge CLK) begin
        mon_stall   = mon_stall + int'(dispatch_stall);
        mon_revert  = mon_revert + int'(revert_valid);
        mon_restore = mon_restore + int'(restore_checkpoint_valid);
        mon_overlap = mon_overlap + int'(revert_valid && restore_checkpoint_valid);
        if (dispatch_stall && !restore_checkpoint_valid && !recover_done)
            walk_q.push_back(ROB_read_index);
        if (revert_valid) begin
            last_arch = revert_dest_arch_reg_tag;
            last_safe = revert_safe_dest_phys_reg_tag;
            last_spec = revert_speculated_dest_phys_reg_tag;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int         s_stall, s_revert, s_restore, s_walk;
    logic [4:0] got_tail, got_ridx;
    logic [2:0] got_rcol;
    logic       got_done;

    task automatic snap();
        s_stall   = mon_stall;
        s_revert  = mon_revert;
        s_restore = mon_restore;
        s_walk    = walk_q.size();
    endtask

    task automatic wait_done();
        got_done = 1'b0;
        got_tail = '0;
        got_ridx = '0;
        got_rcol = '0;
        for (int i = 0; i < 40 && !got_done; i++) begin
            @(negedge CLK);
            if (restore_checkpoint_valid) begin
                got_ridx = restore_checkpoint_ROB_index;
                got_rcol = restore_checkpoint_safe_column;
                check_eq("restore_spec_failed", 32'(restore_checkpoint_speculate_failed), 32'd1);
            end
            if (recover_done) begin
                got_done = 1'b1;
                got_tail = recover_new_ROB_tail;
            end
        end
        check_eq("done_seen", 32'(got_done), 32'd1);
        @(posedge CLK); #1;
    endtask

    task automatic run_req(input logic [4:0] b, input logic [4:0] t, input logic cpv,
                           input logic [2:0] col, input logic succ);
        snap();
        recover_req_valid          = 1'b1;
        recover_ROB_index          = b;
        ROB_tail_index             = t;
        recover_checkpoint_valid   = cpv;
        recover_checkpoint_column  = col;
        restore_checkpoint_success = succ;
        #1;
        check_eq("ready_in_idle", 32'(recover_req_ready), 32'd1);
        @(posedge CLK); #1;
        recover_req_valid = 1'b0;
        wait_done();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rob_wr[i]   = 1'b1;
            rob_arch[i] = arch_reg_tag_t'((i % 31) + 1);
            rob_safe[i] = phys_reg_tag_t'(i) | 6'h20;
            rob_spec[i] = phys_reg_tag_t'(i);
        end
        nRST = 1'b0;
        recover_req_valid = 1'b0;
        recover_ROB_index = '0;
        recover_checkpoint_valid = 1'b0;
        recover_checkpoint_column = '0;
        ROB_tail_index = '0;
        restore_checkpoint_success = 1'b0;
        #12;
        check_eq("rst_ready", 32'(recover_req_ready), 32'd1);
        check_eq("rst_stall", 32'(dispatch_stall), 32'd0);
        check_eq("rst_error", 32'(DUT_error), 32'd0);
        check_eq("rst_outs", {revert_valid, restore_checkpoint_valid, recover_done,
                              recover_new_ROB_tail, ROB_read_index}, 32'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;

        // Checkpoint restore succeeds
        run_req(5'd5, 5'd9, 1'b1, 3'd2, 1'b1);
        check_eq("cp_ok_restore_cnt", 32'(mon_restore - s_restore), 32'd1);
        check_eq("cp_ok_restore_idx", 32'(got_ridx), 32'd5);
        check_eq("cp_ok_restore_col", 32'(got_rcol), 32'd2);
        check_eq("cp_ok_tail", 32'(got_tail), 32'd6);
        check_eq("cp_ok_reverts", 32'(mon_revert - s_revert), 32'd0);
        check_eq("cp_ok_stall", 32'(mon_stall - s_stall), 32'd2);
        check_eq("cp_ok_idle", 32'(recover_req_ready), 32'd1);

        // Checkpoint restore fails, falls back to walk 8,7,6
        run_req(5'd5, 5'd9, 1'b1, 3'd2, 1'b0);
        check_eq("cp_fail_restore_cnt", 32'(mon_restore - s_restore), 32'd1);
        check_eq("cp_fail_reverts", 32'(mon_revert - s_revert), 32'd3);
        check_eq("cp_fail_stall", 32'(mon_stall - s_stall), 32'd5);
        check_eq("cp_fail_walklen", 32'(walk_q.size() - s_walk), 32'd3);
        check_eq("cp_fail_walk0", 32'(walk_q[s_walk]), 32'd8);
        check_eq("cp_fail_walk1", 32'(walk_q[s_walk+1]), 32'd7);
        check_eq("cp_fail_walk2", 32'(walk_q[s_walk+2]), 32'd6);
        check_eq("cp_fail_last_arch", 32'(last_arch), 32'd7);
        check_eq("cp_fail_last_safe", 32'(last_safe), 32'h26);
        check_eq("cp_fail_last_spec", 32'(last_spec), 32'h06);
        check_eq("cp_fail_tail", 32'(got_tail), 32'd6);

        // No checkpoint, walk wraps through index 0: 1,0,31
        run_req(5'd30, 5'd2, 1'b0, 3'd5, 1'b1);
        check_eq("wrap_restore_cnt", 32'(mon_restore - s_restore), 32'd0);
        check_eq("wrap_walk0", 32'(walk_q[s_walk]), 32'd1);
        check_eq("wrap_walk1", 32'(walk_q[s_walk+1]), 32'd0);
        check_eq("wrap_walk2", 32'(walk_q[s_walk+2]), 32'd31);
        check_eq("wrap_reverts", 32'(mon_revert - s_revert), 32'd3);
        check_eq("wrap_last_arch", 32'(last_arch), 32'd1);
        check_eq("wrap_last_safe", 32'(last_safe), 32'h3f);
        check_eq("wrap_tail", 32'(got_tail), 32'd31);

        // Empty walk: T == B+1 goes straight to DONE
        run_req(5'd4, 5'd5, 1'b0, 3'd0, 1'b0);
        check_eq("empty_stall", 32'(mon_stall - s_stall), 32'd1);
        check_eq("empty_pulses", 32'(mon_revert - s_revert + mon_restore - s_restore), 32'd0);
        check_eq("empty_tail", 32'(got_tail), 32'd5);

        // Entry 7 has no destination: skipped but walk continues
        rob_wr[7] = 1'b0;
        run_req(5'd5, 5'd9, 1'b0, 3'd0, 1'b0);
        check_eq("nowr_walklen", 32'(walk_q.size() - s_walk), 32'd3);
        check_eq("nowr_reverts", 32'(mon_revert - s_revert), 32'd2);
        check_eq("nowr_no_error", 32'(DUT_error), 32'd0);
        rob_wr[7] = 1'b1;

        // Writing entry with arch 0 flags a sticky error
        rob_arch[11] = '0;
        run_req(5'd10, 5'd12, 1'b0, 3'd0, 1'b0);
        check_eq("arch0_reverts", 32'(mon_revert - s_revert), 32'd0);
        check_eq("arch0_error", 32'(DUT_error), 32'd1);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check_eq("arch0_error_sticky", 32'(DUT_error), 32'd1);
        rob_arch[11] = arch_reg_tag_t'(12);

        // Reset mid-walk abandons the walk
        recover_req_valid = 1'b1;
        recover_ROB_index = 5'd20;
        ROB_tail_index = 5'd28;
        recover_checkpoint_valid = 1'b0;
        @(posedge CLK); #1;
        recover_req_valid = 1'b0;
        @(posedge CLK); #1;
        check_eq("midwalk_busy", 32'(dispatch_stall), 32'd1);
        check_eq("midwalk_ptr", 32'(ROB_read_index), 32'd26);
        nRST = 1'b0;
        #1;
        check_eq("rst2_ready", 32'(recover_req_ready), 32'd1);
        check_eq("rst2_stall", 32'(dispatch_stall), 32'd0);
        check_eq("rst2_error", 32'(DUT_error), 32'd0);
        check_eq("rst2_outs", {revert_valid, restore_checkpoint_valid, recover_done,
                               recover_new_ROB_tail, ROB_read_index}, 32'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;

        // Second request held while busy is only taken once back in IDLE
        snap();
        recover_req_valid = 1'b1;
        recover_ROB_index = 5'd20;
        ROB_tail_index = 5'd24;
        @(posedge CLK); #1;
        recover_ROB_index = 5'd0;
        ROB_tail_index = 5'd3;
        check_eq("busy_not_ready", 32'(recover_req_ready), 32'd0);
        wait_done();
        check_eq("busy_first_tail", 32'(got_tail), 32'd21);
        check_eq("busy_ready_again", 32'(recover_req_ready), 32'd1);
        @(posedge CLK); #1;
        recover_req_valid = 1'b0;
        wait_done();
        check_eq("busy_second_tail", 32'(got_tail), 32'd1);
        check_eq("busy_walklen", 32'(walk_q.size() - s_walk), 32'd5);
        check_eq("never_overlap", 32'(mon_overlap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/map_table_recovery_controller.md
Name: map_table_recovery_controller

Overview:
- Sequences branch-mispredict recovery of the physical register map table.
- On a recovery request it first tries a single-cycle checkpoint restore of the map table.
- If there is no checkpoint, or the restore fails, it walks the ROB from youngest entry back to the mispredicted branch and issues one revert per cycle.
- Sits in the dispatch unit between the ROB and the map table, and stalls dispatch while recovery is in progress.

Parameters:
- USE_CHECKPOINTS, 1, 0 forces the ROB-walk path for every request (checkpoint restore is never attempted).
- ROB_ENTRIES, 2**$bits(ROB_index_t), ROB depth. Must be a power of two so ROB index arithmetic wraps naturally.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- DUT_error  out  1  registered error flag
- recover_req_valid  in  1  mispredict recovery request
- recover_req_ready  out  1  high only in IDLE; a request is accepted when valid & ready
- recover_ROB_index  in  ROB_index_t  ROB index of the mispredicted branch
- recover_checkpoint_valid  in  1  the branch owns a map table checkpoint
- recover_checkpoint_column  in  checkpoint_column_t  safe column saved at the branch
- ROB_tail_index  in  ROB_index_t  next free ROB slot, one past the youngest entry
- ROB_read_index  out  ROB_index_t  combinational ROB read address
- ROB_read_writes_reg  in  1  the read entry has a destination register
- ROB_read_dest_arch_reg_tag  in  arch_reg_tag_t  destination architectural register of the read entry
- ROB_read_safe_phys_reg_tag  in  phys_reg_tag_t  previous (safe) mapping of that register
- ROB_read_speculated_phys_reg_tag  in  phys_reg_tag_t  mapping installed by the read entry
- revert_valid  out  1  to map table
- revert_dest_arch_reg_tag  out  arch_reg_tag_t  to map table
- revert_safe_dest_phys_reg_tag  out  phys_reg_tag_t  to map table
- revert_speculated_dest_phys_reg_tag  out  phys_reg_tag_t  to map table
- restore_checkpoint_valid  out  1  to map table
- restore_checkpoint_speculate_failed  out  1  to map table
- restore_checkpoint_ROB_index  out  ROB_index_t  to map table
- restore_checkpoint_safe_column  out  checkpoint_column_t  to map table
- restore_checkpoint_success  in  1  from map table, same cycle as the restore
- dispatch_stall  out  1  high in every state except IDLE
- recover_done  out  1  one-cycle completion pulse
- recover_new_ROB_tail  out  ROB_index_t  latched branch index + 1, valid while recover_done is high

Behaviour:
- Reset: state IDLE, latched registers 0, DUT_error 0. All outputs are 0 except recover_req_ready, which is 1.
- Request latch:
  - In IDLE, an accepted request latches branch index B, tail T, the checkpoint column, and cp_ok = recover_checkpoint_valid & USE_CHECKPOINTS.
  - Next state is RESTORE if cp_ok. Otherwise it is WALK if T != B+1, or DONE if T == B+1.
  - While not in IDLE, recover_req_valid is ignored; the requester must hold it.
- RESTORE (exactly 1 cycle):
  - Drive restore_checkpoint_valid=1, restore_checkpoint_speculate_failed=1, restore_checkpoint_ROB_index=B, restore_checkpoint_safe_column=latched column.
  - If restore_checkpoint_success, go to DONE.
  - Otherwise fall back: go to WALK with ptr=T-1, or to DONE if T==B+1.
- WALK:
  - ptr is initialised to T-1 (mod ROB_ENTRIES). ROB_read_index = ptr.
  - revert_valid = ROB_read_writes_reg & (dest_arch != 0). The revert tag fields are passed through from the ROB read data.
  - If ptr == B+1, go to DONE; otherwise ptr <= ptr-1.
  - Entries are reverted youngest first, one per cycle.
  - Walk length is (T-B-1) mod ROB_ENTRIES cycles and wraps through index 0.
- DONE (1 cycle): recover_done=1, recover_new_ROB_tail=B+1, then go to IDLE.
- All map-table-facing outputs are 0 outside their own state. Revert and restore are never driven in the same cycle.
- DUT_error is registered and sticky until reset. It sets in WALK when ROB_read_writes_reg=1 with dest_arch=0.
- Reset mid-operation: immediate return to IDLE with outputs at their reset values; the partial walk is abandoned.

Decomposition:
- Add to core_types_pkg: recovery_state_t enum {RECOV_IDLE, RECOV_RESTORE, RECOV_WALK, RECOV_DONE}.
- Reuse the existing ROB_index_t, checkpoint_column_t, arch_reg_tag_t and phys_reg_tag_t.
- Single module, no sub-module; the FSM and the walk pointer are small enough to live together.

Test Plan:
- Request B=5, T=9, checkpoint valid, column 2; success=1 in RESTORE → restore asserted one cycle with index 5, column 2; recover_done the next cycle with new tail 6; zero reverts.
- Same request, success=0 → one RESTORE cycle, then WALK reads 8,7,6 (3 reverts), then recover_done with new tail 6; dispatch_stall high for 5 cycles.
- Checkpoint invalid, B=30, T=2, ROB_ENTRIES=32 → walk reads 1,0,31 with wrap; recover_done with new tail 31.
- B=4, T=5 with no checkpoint → IDLE, then DONE next cycle; no revert or restore pulses.
- WALK entry with writes_reg=0 at index 7 → revert_valid=0 that cycle, walk continues; an entry with writes_reg=1 and arch 0 → DUT_error=1 next cycle and stays high.
- nRST asserted mid-walk, and a second request while busy → all outputs return to reset values with ready=1; the second request is not accepted until IDLE.
